// File: rtl/pulse_period_meter_pkg.sv
// Shared constants for the pulse period meter: default counter width and FSM encodings.
package pulse_period_meter_pkg;

    localparam int unsigned PPM_DEFAULT_WIDTH = 16;
    localparam int unsigned PPM_STATE_W       = 2;

    localparam logic [PPM_STATE_W-1:0] S_IDLE    = 2'd0;
    localparam logic [PPM_STATE_W-1:0] S_ARM     = 2'd1;
    localparam logic [PPM_STATE_W-1:0] S_MEASURE = 2'd2;

endpackage

// File: rtl/pulse_period_meter_rise_edge_detect.sv
// Rising-edge detector for a signal already synchronous to clk.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic pulse_d;

    // One-cycle delayed copy of the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_d <= 1'b0;
        end else begin
            pulse_d <= din;
        end
    end

    assign rise = din & ~pulse_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in and hands each
// result to a valid/ready consumer; flags dropped results and counter saturation.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH = PPM_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             timeout,
    output logic             armed
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic                   rise;
    logic [PPM_STATE_W-1:0] state;
    logic [PPM_STATE_W-1:0] state_next;
    logic [WIDTH-1:0]       cnt;
    logic                   capture_c;
    logic                   saturate_c;

    rise_edge_detect u_rise_edge_detect (
        .clk   (clk),
        .reset (reset),
        .din   (pulse_in),
        .rise  (rise)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus capture/saturation strobes.
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        saturate_c = 1'b0;
        if (!en) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_ARM;
                end
                S_ARM: begin
                    if (rise) begin
                        state_next = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        capture_c = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        saturate_c = 1'b1;
                        state_next = S_ARM;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Cycle counter: restarts at 1 on every edge, cleared when idle or saturated.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else begin
            case (state)
                S_ARM: begin
                    cnt <= rise ? WIDTH'(1) : '0;
                end
                S_MEASURE: begin
                    if (rise) begin
                        cnt <= WIDTH'(1);
                    end else if (saturate_c) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Result register with handshake, sticky overrun, timeout strobe and armed flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
            armed        <= 1'b0;
        end else begin
            timeout <= saturate_c;
            armed   <= (state_next == S_MEASURE);
            if (!en) begin
                overrun <= 1'b0;
            end
            if (capture_c) begin
                if (!period_valid || period_ready) begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: a timestamp-based reference model predicts
// results and flags, a separate monitor checks every accepted result in order.
module tb_pulse_period_meter;

    localparam int unsigned W    = 4;
    localparam int          MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         pulse_in = 1'b0;
    logic         period_ready = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         overrun;
    logic         timeout;
    logic         armed;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    pulse_period_meter #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun),
        .timeout      (timeout),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge timestamps, evaluated on the negedge before each posedge.
    int   cyc     = 0;
    int   m_last  = -1;
    bit   m_active = 1'b0;
    bit   m_prev  = 1'b0;
    bit   started = 1'b0;
    bit   e_valid = 1'b0;
    bit   e_ovr   = 1'b0;
    bit   e_to    = 1'b0;
    bit   e_arm   = 1'b0;

    always @(negedge clk) begin
        bit rise_m;
        bit cap;
        bit acc;
        int cap_val;
        if (started) begin
            check("period_valid", 32'(period_valid), 32'(e_valid));
            check("overrun", 32'(overrun), 32'(e_ovr));
            check("timeout", 32'(timeout), 32'(e_to));
            check("armed", 32'(armed), 32'(e_arm));
        end
        started = 1'b1;
        rise_m  = pulse_in & ~m_prev;
        cap     = 1'b0;
        cap_val = 0;
        if (reset) begin
            m_prev   = 1'b0;
            m_active = 1'b0;
            m_last   = -1;
            e_valid  = 1'b0;
            e_ovr    = 1'b0;
            e_to     = 1'b0;
            e_arm    = 1'b0;
            exp_q.delete();
        end else begin
            e_to = 1'b0;
            acc  = e_valid & period_ready;
            if (!en) begin
                m_active = 1'b0;
                m_last   = -1;
                e_ovr    = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
            end else if (rise_m) begin
                if (m_last >= 0) begin
                    cap     = 1'b1;
                    cap_val = cyc - m_last;
                end
                m_last = cyc;
            end else if (m_last >= 0 && cyc - m_last == MAXC) begin
                e_to   = 1'b1;
                m_last = -1;
            end
            e_arm = (m_last >= 0);
            if (cap) begin
                if (!e_valid || period_ready) begin
                    exp_q.push_back(W'(cap_val));
                    e_valid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (acc) begin
                e_valid = 1'b0;
            end
            m_prev = pulse_in;
        end
        cyc++;
    end

    // Monitor: every result the DUT hands over must match the oldest expected one.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (reset === 1'b0 && period_valid === 1'b1 && period_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(period), 32'hFFFF_FFFF);
            end else begin
                exp_v = exp_q.pop_front();
                check("period", 32'(period), 32'(exp_v));
            end
        end
    end

    task automatic drive(input logic r, input logic p, input logic e, input logic rd);
        @(posedge clk);
        #1;
        reset        = r;
        pulse_in     = p;
        en           = e;
        period_ready = rd;
    endtask

    task automatic tick_train(input int per, input int cycles, input logic rd);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, (i % per) == 0, 1'b1, rd);
        end
    endtask

    initial begin
        int gap;
        bit en_r;
        // Reset state
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_period", 32'(period), 32'd0);

        // Ticks every 10 cycles with ready high
        tick_train(10, 62, 1'b1);
        // Toggle each cycle: period 2
        tick_train(2, 30, 1'b1);
        // Consumer stalled: first result held, later ones dropped
        tick_train(5, 16, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1);
        // Single tick then silence -> timeout
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (24) drive(1'b0, 1'b0, 1'b1, 1'b1);
        // Held high: one edge only
        repeat (24) drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        // Edge exactly on the saturation cycle, then one cycle too late
        tick_train(MAXC, 3 * MAXC + 1, 1'b1);
        tick_train(MAXC + 1, 3 * (MAXC + 1) + 1, 1'b1);
        // Disable mid-measure, then restart with period 7
        tick_train(6, 9, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick_train(7, 30, 1'b1);
        // Reset while a result is pending and overrun is set
        tick_train(5, 16, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_period_pending", 32'(period), 32'd0);

        // Randomized traffic
        gap  = 0;
        en_r = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            logic p;
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            if ($urandom_range(0, 999) == 0) begin
                drive(1'b1, 1'b0, en_r, 1'b0);
                continue;
            end
            if (gap == 0) begin
                p   = 1'b1;
                gap = $urandom_range(1, MAXC + 2);
            end else begin
                p   = ($urandom_range(0, 7) == 0) ? pulse_in : 1'b0;
                gap--;
            end
            drive(1'b0, p, en_r, $urandom_range(0, 3) != 0);
        end

        // Drain
        repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
